// File: rtl/alu_op_decoder.sv
// Registered ALU operation decoder: maps instruction class, funct3 and funct7[5]
// to a 4-bit ALU op code with a stall enable and an illegal-encoding flag.
module alu_op_decoder #(
   parameter logic [3:0] RESET_OP = 4'b0010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       funct7_b5,
   input  logic [2:0] funct3,
   input  logic [1:0] instruction_type,
   output logic [3:0] alu_op,
   output logic       illegal
);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOr   = 4'b0001;
   localparam logic [3:0] OpAdd  = 4'b0010;
   localparam logic [3:0] OpXor  = 4'b0011;
   localparam logic [3:0] OpSll  = 4'b0100;
   localparam logic [3:0] OpSrl  = 4'b0101;
   localparam logic [3:0] OpSub  = 4'b0110;
   localparam logic [3:0] OpSra  = 4'b0111;
   localparam logic [3:0] OpSlt  = 4'b1000;
   localparam logic [3:0] OpSltu = 4'b1001;

   logic [3:0] alu_op_d, alu_op_q;
   logic       illegal_d, illegal_q;
   logic [3:0] base_op;

   // Shared R/I-type table for the funct7_b5=0 column.
   always_comb begin
      base_op = OpAdd;
      unique case (funct3)
         3'b000: base_op = OpAdd;
         3'b001: base_op = OpSll;
         3'b010: base_op = OpSlt;
         3'b011: base_op = OpSltu;
         3'b100: base_op = OpXor;
         3'b101: base_op = OpSrl;
         3'b110: base_op = OpOr;
         3'b111: base_op = OpAnd;
         default: base_op = OpAdd;
      endcase
   end

   always_comb begin
      alu_op_d  = OpAdd;
      illegal_d = 1'b0;
      unique case (instruction_type)
         2'b00: alu_op_d = OpAdd;
         2'b01: begin
            unique case (funct3[2:1])
               2'b00:   alu_op_d = OpSub;
               2'b10:   alu_op_d = OpSlt;
               2'b11:   alu_op_d = OpSltu;
               default: illegal_d = 1'b1;
            endcase
         end
         2'b10: begin
            if (!funct7_b5) begin
               alu_op_d = base_op;
            end else if (funct3 == 3'b000) begin
               alu_op_d = OpSub;
            end else if (funct3 == 3'b101) begin
               alu_op_d = OpSra;
            end else begin
               illegal_d = 1'b1;
            end
         end
         2'b11: begin
            if (funct3 == 3'b101) begin
               alu_op_d = funct7_b5 ? OpSra : OpSrl;
            end else if (funct3 == 3'b001 && funct7_b5) begin
               illegal_d = 1'b1;
            end else begin
               alu_op_d = base_op;
            end
         end
         default: illegal_d = 1'b1;
      endcase
      if (illegal_d) begin
         alu_op_d = RESET_OP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_op_q  <= RESET_OP;
         illegal_q <= 1'b0;
      end else if (en) begin
         alu_op_q  <= alu_op_d;
         illegal_q <= illegal_d;
      end
   end

   assign alu_op  = alu_op_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: stimulus pushes expected register contents,
// an independent monitor pops and compares one entry per clock edge.
module tb_alu_op_decoder;

   localparam logic [3:0] RESET_OP = 4'b0010;
   localparam logic [3:0] AND_ = 4'd0, OR_ = 4'd1, ADD = 4'd2, XOR_ = 4'd3, SLL = 4'd4;
   localparam logic [3:0] SRL = 4'd5, SUB = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       funct7_b5 = 1'b0;
   logic [2:0] funct3 = 3'd0;
   logic [1:0] instruction_type = 2'd0;
   logic [3:0] alu_op;
   logic       illegal;

   typedef struct packed {
      logic [3:0] op;
      logic       ill;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] m_op = RESET_OP;
   logic       m_ill = 1'b0;

   alu_op_decoder #(.RESET_OP(RESET_OP)) dut (
      .clk              (clk),
      .reset            (reset),
      .en               (en),
      .funct7_b5        (funct7_b5),
      .funct3           (funct3),
      .instruction_type (instruction_type),
      .alu_op           (alu_op),
      .illegal          (illegal)
   );

   always #5 clk = ~clk;

   // Reference decode straight from the instruction-set rules.
   function automatic exp_t ref_decode(logic [1:0] t, logic [2:0] f3, logic b5);
      logic [3:0] rtab[8];
      logic [3:0] btab[4];
      exp_t       r;
      rtab = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
      btab = '{SUB, RESET_OP, SLT, SLTU};
      r = '{op: RESET_OP, ill: 1'b1};
      if (t == 2'd0) begin
         r = '{op: ADD, ill: 1'b0};
      end else if (t == 2'd1) begin
         if (f3 != 3'd2 && f3 != 3'd3) r = '{op: btab[int'(f3) / 2], ill: 1'b0};
      end else if (t == 2'd2) begin
         if (!b5) r = '{op: rtab[f3], ill: 1'b0};
         else if (f3 == 3'd0) r = '{op: SUB, ill: 1'b0};
         else if (f3 == 3'd5) r = '{op: SRA, ill: 1'b0};
      end else begin
         if (f3 == 3'd5) r = '{op: (b5 ? SRA : SRL), ill: 1'b0};
         else if (!(f3 == 3'd1 && b5)) r = '{op: rtab[f3], ill: 1'b0};
      end
      return r;
   endfunction

   task automatic step(input logic r, input logic e, input logic [1:0] t,
                       input logic [2:0] f3, input logic b5);
      exp_t d;
      @(negedge clk);
      reset = r;
      en = e;
      instruction_type = t;
      funct3 = f3;
      funct7_b5 = b5;
      if (r) begin
         m_op = RESET_OP;
         m_ill = 1'b0;
      end else if (e) begin
         d = ref_decode(t, f3, b5);
         m_op = d.op;
         m_ill = d.ill;
      end
      q.push_back('{op: m_op, ill: m_ill});
   endtask

   // Monitor: the registered outputs are valid one edge after each issued step.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (alu_op !== e.op) begin
               errors++;
               $display("FAIL alu_op: got %b expected %b (t=%b f3=%b b5=%b)",
                        alu_op, e.op, instruction_type, funct3, funct7_b5);
            end
            checks++;
            if (illegal !== e.ill) begin
               errors++;
               $display("FAIL illegal: got %b expected %b (t=%b f3=%b b5=%b)",
                        illegal, e.ill, instruction_type, funct3, funct7_b5);
            end
            checks++;
            if (alu_op > 4'd9) begin
               errors++;
               $display("FAIL op_range: got %b expected <= 1001", alu_op);
            end
         end
      end
   end

   initial begin
      // Reset with R-type SUB applied, then release.
      step(1'b1, 1'b1, 2'd2, 3'd0, 1'b1);
      step(1'b1, 1'b1, 2'd2, 3'd0, 1'b1);
      step(1'b0, 1'b1, 2'd2, 3'd0, 1'b1);
      for (int f = 0; f < 8; f++) step(1'b0, 1'b1, 2'd2, 3'(f), 1'b0);
      step(1'b0, 1'b1, 2'd2, 3'd0, 1'b1);
      step(1'b0, 1'b1, 2'd2, 3'd5, 1'b1);
      step(1'b0, 1'b1, 2'd3, 3'd0, 1'b1);
      step(1'b0, 1'b1, 2'd3, 3'd5, 1'b1);
      step(1'b0, 1'b1, 2'd3, 3'd1, 1'b1);
      step(1'b0, 1'b1, 2'd0, 3'd2, 1'b0);
      step(1'b0, 1'b1, 2'd1, 3'd0, 1'b0);
      step(1'b0, 1'b1, 2'd1, 3'd4, 1'b0);
      step(1'b0, 1'b1, 2'd1, 3'd7, 1'b0);
      step(1'b0, 1'b1, 2'd1, 3'd2, 1'b0);
      // Stall on AND, then drive OR with en low.
      step(1'b0, 1'b1, 2'd2, 3'd7, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd2, 3'd6, 1'b0);
      step(1'b0, 1'b1, 2'd2, 3'd6, 1'b0);
      // Illegal result held across a stall, then cleared by reset.
      step(1'b0, 1'b1, 2'd2, 3'd3, 1'b1);
      step(1'b0, 1'b0, 2'd2, 3'd0, 1'b0);
      step(1'b1, 1'b1, 2'd2, 3'd7, 1'b0);
      for (int c = 0; c < 64; c++) step(1'b0, 1'b1, 2'(c >> 4), 3'(c >> 1), 1'(c));
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(31) == 0), 1'($urandom_range(3) != 0),
              2'($urandom), 3'($urandom), 1'($urandom));
      end
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
